// File: rtl/piso_register.sv
// ---------------------------------------------------------------------------
// piso_register
//
// Parallel-in / serial-out shift register with a valid/ready serial side.
// A word is captured from d when ld is high while idle. Its bits are then
// presented one per beat on sout. A beat completes on each rising edge where
// sout_valid and sout_ready are both high.
//
// Parameters
//   WIDTH     : parallel word width in bits (2..32)
//   MSB_FIRST : 1 = bit WIDTH-1 goes out first, 0 = bit 0 goes out first
//
// Optional feature (compile-time macro PISO_PARITY_EN)
//   When defined, one extra beat follows the data beats. It carries the even
//   parity (XOR) of the captured word, and last is asserted on that beat only.
//   When undefined, every word is exactly WIDTH beats.
//
// Ports
//   clk        in   clock; all state changes on its rising edge
//   rst        in   asynchronous, active-high reset
//   ld         in   capture d and start a word (honoured only when idle)
//   d          in   parallel data word, WIDTH bits
//   sout_ready in   consumer accepts the current serial bit
//   sout       out  current serial bit (0 when idle)
//   sout_valid out  sout holds a valid bit
//   last       out  current beat is the final beat of the word
//   busy       out  a word is in flight; ld is ignored
// ---------------------------------------------------------------------------
module piso_register #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             sout_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int             CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  FINAL_BEAT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef PISO_PARITY_EN
    SHIFT  = 2'd1,
    PARITY = 2'd2
`else
    SHIFT  = 2'd1
`endif
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
`ifdef PISO_PARITY_EN
  logic             par, par_nxt;
`endif

  // Bit currently at the output end of the shift register.
  function automatic logic head_bit(input logic [WIDTH-1:0] word);
    if (MSB_FIRST != 0) return word[WIDTH-1];
    else                return word[0];
  endfunction

  // Advance the shift register by one beat. Zeros fill in behind, so the
  // register is empty again once a whole word has been sent.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] word);
    if (MSB_FIRST != 0) return {word[WIDTH-2:0], 1'b0};
    else                return {1'b0, word[WIDTH-1:1]};
  endfunction

`ifdef PISO_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  // State register: capture stage for control and data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
`ifdef PISO_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
`ifdef PISO_PARITY_EN
      par   <= par_nxt;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
`ifdef PISO_PARITY_EN
    par_nxt   = par;
`endif
    case (state)
      IDLE: begin
        if (ld) begin
          sreg_nxt  = d;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
`ifdef PISO_PARITY_EN
          // Parity comes from the captured word, so later d changes cannot
          // affect it.
          par_nxt   = even_parity(d);
`endif
        end
      end
      SHIFT: begin
        // sout_valid is always high here, so a ready edge is an accepted beat.
        // ld is not looked at, which also covers ld on the final beat.
        if (sout_ready) begin
          sreg_nxt = shift_once(sreg);
          if (cnt == FINAL_BEAT) begin
`ifdef PISO_PARITY_EN
            cnt_nxt   = cnt + CNT_ONE;  // reaches WIDTH, its upper bound
            state_nxt = PARITY;
`else
            cnt_nxt   = '0;
            state_nxt = IDLE;
`endif
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (sout_ready) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        sreg_nxt  = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode: driven purely from registered state, so reset clears the
  // outputs immediately without waiting for a clock edge.
  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    case (state)
      SHIFT: begin
        sout       = head_bit(sreg);
        sout_valid = 1'b1;
        busy       = 1'b1;
`ifdef PISO_PARITY_EN
        last       = 1'b0;
`else
        last       = (cnt == FINAL_BEAT);
`endif
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        sout       = par;
        sout_valid = 1'b1;
        busy       = 1'b1;
        last       = 1'b1;
      end
`endif
      default: begin
        sout       = 1'b0;
        sout_valid = 1'b0;
        last       = 1'b0;
        busy       = 1'b0;
      end
    endcase
  end

endmodule
